game_match_controller: RTL and testbench

Match-level controller above the game master FSM. It owns the end-of-game timer that the master starts on every won or lost round, and it keeps a per-match score. It stalls the master at the end of a match until the player presses the key again. It drives the master's `end_of_game_timer_running` input and consumes the master's `end_of_game_timer_start` and `game_won` outputs.

---
 rtl/game_match_controller.sv | 132 +++++++++++++
 tb/tb_game_match_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/game_match_controller.sv
// Match-level controller sitting above the game master FSM.
// Owns the end-of-game timer, keeps the per-match score, and holds the
// master in its end state after a decided match until the key is pressed.
//
// state      | meaning
// -----------+----------------------------------------------------------
// PLAY       | round in progress, waiting for the master's start pulse
// ROUND_END  | timer running after a non-final round
// MATCH_END  | timer running after the deciding round
// MATCH_HOLD | match decided, master stalled until a key rising edge
module game_match_controller #(
  parameter int ROUNDS       = 5,
  parameter int WIN_TARGET   = 3,
  parameter int ROUND_CYCLES = 50_000_000,
  parameter int MATCH_CYCLES = 150_000_000,
  localparam int SW          = $clog2(ROUNDS + 1),
  localparam int MAXC        = (ROUND_CYCLES > MATCH_CYCLES) ? ROUND_CYCLES : MATCH_CYCLES,
  localparam int TW          = $clog2(MAXC + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          key,
  input  logic          end_of_game_timer_start,
  input  logic          game_won,
  output logic          end_of_game_timer_running,
  output logic [SW-1:0] rounds_won,
  output logic [SW-1:0] rounds_lost,
  output logic          match_over,
  output logic          match_won
);

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    ROUND_END  = 2'd1,
    MATCH_END  = 2'd2,
    MATCH_HOLD = 2'd3
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [SW-1:0] r_won;
  logic [SW-1:0] r_lost;
  logic          r_running;
  logic          r_over;
  logic          r_match_won;
  logic          r_key_d;

  logic [SW-1:0] w_won_next;
  logic [SW-1:0] w_lost_next;
  logic [SW:0]   w_total_next;
  logic          w_reached_target;
  logic          w_decided;
  logic          w_key_rise;
  logic          w_timer_zero;

  // Score after the round being reported and whether that decides the match.
  always_comb begin
    w_won_next       = r_won;
    w_lost_next      = r_lost;
    if (game_won) w_won_next  = r_won + SW'(1);
    else          w_lost_next = r_lost + SW'(1);
    w_total_next     = {1'b0, w_won_next} + {1'b0, w_lost_next};
    w_reached_target = (w_won_next == SW'(WIN_TARGET));
    w_decided        = w_reached_target || (w_total_next == (SW+1)'(ROUNDS));
    w_key_rise       = key && !r_key_d;
    w_timer_zero     = (r_timer == '0);
  end

  // Match FSM with timer, scores and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= PLAY;
      r_timer     <= '0;
      r_won       <= '0;
      r_lost      <= '0;
      r_running   <= 1'b0;
      r_over      <= 1'b0;
      r_match_won <= 1'b0;
      r_key_d     <= 1'b0;
    end else begin
      r_key_d <= key;
      case (r_state)
        PLAY: begin
          if (end_of_game_timer_start) begin
            r_won     <= w_won_next;
            r_lost    <= w_lost_next;
            r_running <= 1'b1;
            if (w_decided) begin
              r_state     <= MATCH_END;
              r_timer     <= TW'(MATCH_CYCLES - 1);
              r_over      <= 1'b1;
              r_match_won <= w_reached_target;
            end else begin
              r_state <= ROUND_END;
              r_timer <= TW'(ROUND_CYCLES - 1);
            end
          end
        end
        ROUND_END: begin
          if (w_timer_zero) begin
            r_state   <= PLAY;
            r_running <= 1'b0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        MATCH_END: begin
          if (w_timer_zero) r_state <= MATCH_HOLD;
          else              r_timer <= r_timer - TW'(1);
        end
        MATCH_HOLD: begin
          if (w_key_rise) begin
            r_state     <= PLAY;
            r_won       <= '0;
            r_lost      <= '0;
            r_running   <= 1'b0;
            r_over      <= 1'b0;
            r_match_won <= 1'b0;
          end
        end
        default: r_state <= PLAY;
      endcase
    end
  end

  assign end_of_game_timer_running = r_running;
  assign rounds_won                = r_won;
  assign rounds_lost               = r_lost;
  assign match_over                = r_over;
  assign match_won                 = r_match_won;

endmodule

// File: tb/tb_game_match_controller.sv
// Directed bench for game_match_controller with small timer lengths.
module tb_game_match_controller;

  localparam int ROUNDS       = 3;
  localparam int WIN_TARGET   = 2;
  localparam int ROUND_CYCLES = 4;
  localparam int MATCH_CYCLES = 8;
  localparam int SW           = $clog2(ROUNDS + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          key = 1'b0;
  logic          start = 1'b0;
  logic          game_won = 1'b0;
  logic          running;
  logic [SW-1:0] rounds_won;
  logic [SW-1:0] rounds_lost;
  logic          match_over;
  logic          match_won;

  int n_total = 0;
  int n_bad   = 0;

  game_match_controller #(
    .ROUNDS(ROUNDS),
    .WIN_TARGET(WIN_TARGET),
    .ROUND_CYCLES(ROUND_CYCLES),
    .MATCH_CYCLES(MATCH_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key(key),
    .end_of_game_timer_start(start),
    .game_won(game_won),
    .end_of_game_timer_running(running),
    .rounds_won(rounds_won),
    .rounds_lost(rounds_lost),
    .match_over(match_over),
    .match_won(match_won)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n clock edges; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle start pulse from the master; returns at cycle t+1.
  task automatic pulse(input logic won);
    start    = 1'b1;
    game_won = won;
    tick(1);
    start    = 1'b0;
    game_won = 1'b0;
  endtask

  task automatic chk_all(input string tag, input int run, input int w, input int l,
                         input int ov, input int mw);
    chk({tag, ".running"}, int'(running), run);
    chk({tag, ".won"}, int'(rounds_won), w);
    chk({tag, ".lost"}, int'(rounds_lost), l);
    chk({tag, ".over"}, int'(match_over), ov);
    chk({tag, ".mwon"}, int'(match_won), mw);
  endtask

  initial begin
    // 1: reset, key activity in PLAY has no effect
    tick(2);
    reset = 1'b0;
    chk_all("reset", 0, 0, 0, 0, 0);
    key = 1'b1; tick(1);
    key = 1'b0; tick(1);
    key = 1'b1; tick(1);
    key = 1'b0; tick(1);
    chk_all("key_play", 0, 0, 0, 0, 0);

    // 2: single win, round timer for exactly ROUND_CYCLES cycles
    pulse(1'b1);
    chk_all("win1_t1", 1, 1, 0, 0, 0);
    for (int i = 2; i <= ROUND_CYCLES; i++) begin
      tick(1);
      chk("win1_run_hold", int'(running), 1);
    end
    tick(1);
    chk_all("win1_t5", 0, 1, 0, 0, 0);

    // 3: second win decides the match, stall until key rise
    pulse(1'b1);
    chk_all("win2_t1", 1, 2, 0, 1, 1);
    tick(10);
    chk_all("win2_t11", 1, 2, 0, 1, 1);
    key = 1'b1;
    tick(1);
    chk_all("restart1", 0, 0, 0, 0, 0);
    key = 1'b0;
    tick(1);

    // 4: lose, win, lose -> match lost on round count; pulses land as PLAY re-enters
    pulse(1'b0);
    chk_all("l1", 1, 0, 1, 0, 0);
    tick(ROUND_CYCLES);
    chk("l1_done", int'(running), 0);
    pulse(1'b1);
    chk_all("w2", 1, 1, 1, 0, 0);
    tick(ROUND_CYCLES);
    pulse(1'b0);
    chk_all("l3", 1, 1, 2, 1, 0);

    // 5: key held high through the match end does not restart
    key = 1'b1;
    tick(MATCH_CYCLES + 4);
    chk_all("key_held", 1, 1, 2, 1, 0);
    key = 1'b0;
    tick(1);
    chk_all("key_low", 1, 1, 2, 1, 0);
    key = 1'b1;
    tick(1);
    chk_all("restart2", 0, 0, 0, 0, 0);
    key = 1'b0;
    tick(1);

    // 6: start pulse mid-ROUND_END ignored; reset mid-MATCH_END
    pulse(1'b1);
    tick(1);
    pulse(1'b0);
    chk_all("mid_pulse", 1, 1, 0, 0, 0);
    tick(1);
    chk("mid_run_t4", int'(running), 1);
    tick(1);
    chk_all("mid_t5", 0, 1, 0, 0, 0);
    pulse(1'b1);
    chk_all("win_b", 1, 2, 0, 1, 1);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk_all("reset_mid", 0, 0, 0, 0, 0);
    pulse(1'b1);
    chk_all("after_reset", 1, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Guard against a stuck simulation.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
